// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
// Parity support in the consuming RTL is selected with FIFO_UART_TX_PARITY_EN.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_e;

  localparam logic        START_BIT = 1'b0;
  localparam logic        STOP_BIT  = 1'b1;
  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned BIT_IDX_W = $clog2(DATA_BITS);

  // Even parity: the line bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last and
// second-to-last cycle of each bit period, both as registered strobes.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clock,
  input  logic rst,
  input  logic clr,
  output logic bit_end,
  output logic bit_pre
);

  localparam int unsigned    CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] PRE   = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bit_end_q, bit_pre_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Strobes are registered off the next count so they line up with cnt_q.
  always_ff @(posedge clock) begin
    if (rst) begin
      cnt_q     <= '0;
      bit_end_q <= 1'b0;
      bit_pre_q <= (PRE == '0);
    end else begin
      cnt_q     <= cnt_d;
      bit_end_q <= (cnt_d == LAST);
      bit_pre_q <= (cnt_d == PRE);
    end
  end

  assign bit_end = bit_end_q;
  assign bit_pre = bit_pre_q;

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one byte at a time and serialises it as 8N1,
// or 8E1 when FIFO_UART_TX_PARITY_EN is defined.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 tx_en,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_dout,
  output logic                 fifo_rd,
  output logic                 tx,
  output logic                 busy,
  output logic                 byte_done
);

  state_e                 state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   baud_clr;
  logic                   bit_end;
  logic                   bit_pre;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                   par_q, par_d;
`endif

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clock  (clock),
    .rst    (rst),
    .clr    (baud_clr),
    .bit_end(bit_end),
    .bit_pre(bit_pre)
  );

  // Next-state and next-output logic; line outputs follow the next state.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    done_d    = 1'b0;
    baud_clr  = 1'b0;
    tx_d      = STOP_BIT;
`ifdef FIFO_UART_TX_PARITY_EN
    par_d     = par_q;
`endif

    case (state_q)
      IDLE: begin
        baud_clr = 1'b1;
        if (tx_en && !fifo_empty) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        baud_clr  = 1'b1;
        shift_d   = fifo_dout;
        bit_idx_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
        par_d     = even_parity(fifo_dout);
`endif
        state_d   = START;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
          if (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        // bit_pre marks the cycle before the final stop cycle.
        done_d = bit_pre;
        if (bit_end) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    case (state_d)
      START:   tx_d = START_BIT;
      DATA:    tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = STOP_BIT;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= STOP_BIT;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  // Pop strobe is a pure state decode so it can never glitch.
  assign fifo_rd   = (state_q == FETCH);
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign byte_done = done_q;

endmodule
